// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D-cache memory arbiter.
// ARB_RR_EN (see mem_arbiter) selects round-robin instead of fixed D-first priority.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // One-hot grant vector bit positions.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  // Last-grant flag encoding: the requester that was served most recently.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of I-cache, D-cache and memory-side signals around the arbiter.
// master = arbiter view, slave = environment (caches + memory) view.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_mem_read, i_mem_addr,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  mem_rdata, mem_ready,
    output i_mem_rdata, i_mem_ready,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output i_mem_read, i_mem_addr,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output mem_rdata, mem_ready,
    input  i_mem_rdata, i_mem_ready,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_sel.sv
// Two-way grant selector: lone requester wins; on a tie the requester
// that was not served last wins (last_grant tied to LAST_I gives D-first).
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (i_req && d_req) begin
      if (last_grant == LAST_D) begin
        grant[GNT_I] = 1'b1;
      end else begin
        grant[GNT_D] = 1'b1;
      end
    end else if (d_req) begin
      grant[GNT_D] = 1'b1;
    end else if (i_req) begin
      grant[GNT_I] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between I-cache and D-cache line requests.
// Define ARB_RR_EN for round-robin arbitration; default build is fixed D-first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; requests sampled each cycle, mem_* held 0
// GRANT_I | I-cache line read issued; waiting for mem_ready
// GRANT_D | D-cache read or writeback issued; waiting for mem_ready
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic       clk,
  input logic       proc_reset,
  mem_arb_if.master bus
);

  arb_state_e        state, state_nxt;
  logic              rd_q, rd_nxt;
  logic              wr_q, wr_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;

  logic       i_req;
  logic       d_req;
  logic       last_grant;
  logic [1:0] grant;

  assign i_req = bus.i_mem_read;
  assign d_req = bus.d_mem_read | bus.d_mem_write;

`ifdef ARB_RR_EN
  logic last_q;

  // Reset value LAST_D hands the first tie to the I-cache.
  always_ff @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      last_q <= LAST_D;
    end else if (state == IDLE && grant != 2'b00) begin
      last_q <= grant[GNT_D] ? LAST_D : LAST_I;
    end
  end

  assign last_grant = last_q;
`else
  assign last_grant = LAST_I;
`endif

  mem_arb_sel u_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      IDLE: begin
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = '0;
        if (grant[GNT_D]) begin
          state_nxt = GRANT_D;
          // Writeback takes precedence over a simultaneous line read.
          wr_nxt    = bus.d_mem_write;
          rd_nxt    = bus.d_mem_read & ~bus.d_mem_write;
          addr_nxt  = bus.d_mem_addr;
          wdata_nxt = bus.d_mem_wdata;
        end else if (grant[GNT_I]) begin
          state_nxt = GRANT_I;
          rd_nxt    = 1'b1;
          addr_nxt  = bus.i_mem_addr;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_ready) begin
          state_nxt = IDLE;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          addr_nxt  = '0;
          wdata_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Ready is qualified by the current owner so a stray mem_ready in IDLE goes nowhere.
  assign bus.i_mem_ready = bus.mem_ready && (state == GRANT_I);
  assign bus.d_mem_ready = bus.mem_ready && (state == GRANT_D);
  assign bus.i_mem_rdata = bus.mem_rdata;
  assign bus.d_mem_rdata = bus.mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 28, block address width; DATA_W, 128, line width.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- proc_reset  in  1  asynchronous, active-low reset.
- i_mem_read  in  1  I-cache line-read request, level, held until served.
- i_mem_addr  in  ADDR_W  I-cache block address.
- i_mem_rdata  out  DATA_W  line data to I-cache.
- i_mem_ready  out  1  I-cache completion strobe.
- d_mem_read  in  1  D-cache line-read request.
- d_mem_write  in  1  D-cache line-writeback request.
- d_mem_addr  in  ADDR_W  D-cache block address.
- d_mem_wdata  in  DATA_W  D-cache writeback line.
- d_mem_rdata  out  DATA_W  line data to D-cache.
- d_mem_ready  out  1  D-cache completion strobe.
- mem_read  out  1  memory read request, registered.
- mem_write  out  1  memory write request, registered.
- mem_addr  out  ADDR_W  memory block address, registered.
- mem_wdata  out  DATA_W  memory write line, registered.
- mem_rdata  in  DATA_W  memory read line.
- mem_ready  in  1  memory completion strobe, one cycle.

Function
REQ-003 SHALL implement FSM states IDLE, GRANT_I, GRANT_D; one transaction at a time, no overlap.
REQ-004 In IDLE, SHALL sample requests each cycle; on a grant, the next cycle SHALL enter GRANT_x with mem_read/mem_write/mem_addr/mem_wdata loaded from the granted requester (one-cycle grant latency).
REQ-005 In IDLE, with no requests, SHALL hold all mem_* outputs at 0.
REQ-006 d_mem_write SHALL map to mem_write, d_mem_read to mem_read; if both asserted, write wins and the read is ignored for that grant.
REQ-007 In GRANT_x, mem_* outputs SHALL stay constant until mem_ready; requester input changes SHALL be ignored.
REQ-008 x_mem_ready SHALL equal mem_ready AND (state == GRANT_x), combinational; the non-granted ready SHALL be 0.
REQ-009 i_mem_rdata and d_mem_rdata SHALL both equal mem_rdata combinationally; validity qualified only by the respective ready.
REQ-010 On mem_ready in GRANT_x, the next cycle SHALL be IDLE with all mem_* outputs cleared to 0; the served requester deasserts its request that same cycle, so no re-grant occurs.
REQ-011 mem_ready while in IDLE SHALL be ignored (no ready forwarded, no state change).
REQ-012 Simultaneous I and D requests in IDLE SHALL be resolved per REQ-016/017; the loser stays pending and is granted at the next IDLE.
REQ-013 Every transaction SHALL take at least 3 cycles: request cycle, grant cycle, ready cycle.

Reset
REQ-014 proc_reset low SHALL asynchronously force state IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, priority flag = I-cache-next.
REQ-015 Reset mid-transaction SHALL abandon the transaction; no ready SHALL be forwarded; operation resumes from IDLE on the first edge after release.

Configuration
REQ-016 With ARB_RR_EN defined: round-robin; a 1-bit last-grant register SHALL give priority to the requester not granted most recently; it updates only on grant.
REQ-017 Without ARB_RR_EN: fixed priority, D-cache always wins over I-cache; no last-grant register.

Structure
REQ-018 Shared package mem_arb_pkg SHALL hold the state encoding (2-bit: IDLE=0, GRANT_I=1, GRANT_D=2) and the ADDR_W/DATA_W defaults.
REQ-019 Grant selection SHALL be a sub-module mem_arb_sel (inputs: two request levels, last-grant flag; output: one-hot grant); mem_arbiter holds the FSM and output registers.

Verification
REQ-020 Benches SHALL cover:
- I-read alone, addr 0x0000010, mem_ready 4 cycles after mem_read -> mem_read=1 from cycle 2, i_mem_ready=1 one cycle, i_mem_rdata=mem_rdata, d_mem_ready=0 throughout.
- D-write alone, addr 0x00000A3, wdata 0xDEAD...F625 -> mem_write=1, mem_addr=0x00000A3, mem_wdata matches until ready; mem_read stays 0.
- I-read and D-read together from IDLE (ARB_RR_EN, after reset) -> I served first, then D; without macro -> D first.
- Back-to-back D requests with I pending (ARB_RR_EN) -> grants alternate D, I, D; without macro -> I waits until D idles.
- proc_reset low during GRANT_D before mem_ready -> all mem_* outputs 0 immediately, no d_mem_ready; pending I-read granted after release.
- Spurious mem_ready in IDLE -> no ready forwarded, outputs unchanged.
